jtag_debug_sys_mem_tester: RTL and testbench
============================================

Name: jtag_debug_sys_mem_tester

Overview:
Avalon-MM master that drives the on-chip memory slave port (address/byteenable/chipselect/write/writedata in, readdata out) for debug bring-up. On command it either fills a window of the memory with a generated pattern or reads the window back and checks it against the same pattern. It records the mismatch count and the first failing location. It sits between the JTAG debug control registers and the memory's s1 port.

Parameters:
ADDR_W, 10, word-address width; matches the memory's address port.
DATA_W, 32, data width; matches the memory's readdata/writedata.
READ_LATENCY, 1, fixed cycles from an accepted read to valid readdata; legal range 1..4.
ERR_W, 16, width of the saturating mismatch counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  single-cycle command strobe; sampled only in IDLE
op  in  1  0 = fill, 1 = verify
pat_incr  in  1  0 = constant pattern (seed); 1 = incrementing pattern (seed + i)
base  in  ADDR_W  first word address
len  in  ADDR_W+1  number of words (0..2^ADDR_W)
seed  in  DATA_W  pattern seed
m_address  out  ADDR_W  master address
m_byteenable  out  DATA_W/8  always all-ones while m_chipselect is high, else 0
m_chipselect  out  1  transfer request
m_write  out  1  write qualifier
m_writedata  out  DATA_W  write data
m_readdata  in  DATA_W  read data from slave
m_waitrequest  in  1  slave stall; tie 0 for on-chip memory
m_clken  out  1  slave clock enable; 1 except while in RESET/IDLE with no traffic
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at command completion
err_count  out  ERR_W  verify mismatches; saturates at all-ones
first_err_valid  out  1  at least one mismatch in the last verify
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_data  out  DATA_W  readdata observed at the first mismatch

Behaviour:
- Reset (synchronous): all outputs 0 (m_clken 0), FSM to IDLE, read pipeline flushed. This applies mid-operation as well: m_chipselect is 0 from the edge at which reset is sampled, and no done pulse is produced.
- FSM states:
  - IDLE: on start, latch op/pat_incr/base/len/seed. If len == 0, go to DONE. Otherwise go to ISSUE. err_count, first_err_* and first_err_valid clear on every accepted start.
  - ISSUE: drives m_chipselect = 1, m_write = ~op, m_address = base + i (mod 2^ADDR_W, so the address wraps), m_writedata = pattern(i), where i is the issue index.
    - A transfer is accepted in a cycle where m_chipselect = 1 and m_waitrequest = 0. On acceptance i increments.
    - While m_waitrequest = 1, address, data and controls are held stable.
    - After the acceptance with i == len-1: a fill goes to DONE; a verify goes to DRAIN.
  - DRAIN (verify only): m_chipselect = 0; wait until all outstanding reads have returned, then go to DONE.
  - DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
- busy is 1 in ISSUE and DRAIN.
- start while busy is ignored.
- pattern(i) = seed when pat_incr = 0; seed + i (mod 2^DATA_W) when pat_incr = 1.
- Read tracking: a READ_LATENCY-deep shift pipe carries {valid, address, expected}. An entry is pushed on each accepted read and advances every cycle.
  - At the pipe output with valid set, m_readdata is compared against expected.
  - On a mismatch, err_count increments (saturating). If first_err_valid is 0, first_err_addr/data are captured and first_err_valid is set.
  - Issue is back-to-back: one read accepted per cycle when no stall. Throughput is 1 word/cycle.
- Verify completion latency: done asserts READ_LATENCY+1 cycles after the last accepted read, so all compare results are final when done is seen.
- Fill completion: done asserts 1 cycle after the last accepted write.
- len = 2^ADDR_W with base != 0 wraps through address 0. Each word is touched exactly once.
- Error outputs hold their values until the next accepted start or reset.

Test Plan:
- Fill then verify, all compares pass: fill base=0x000, len=1024, pat_incr=1, seed=0x1000_0000, waitrequest=0 -> 1024 consecutive write cycles; mem[5]=0x1000_0005; done 1 cycle after the last write. Verify with the same settings -> err_count=0, first_err_valid=0, done READ_LATENCY+1 cycles after the last read.
- Injected mismatches: fill len=16, seed=0xA5A5A5A5, constant pattern; backdoor-corrupt words 3 and 9 to 0; verify -> err_count=2, first_err_addr=3, first_err_data=0.
- Address wrap: base=0x3FE, len=4 -> accepted addresses 0x3FE, 0x3FF, 0x000, 0x001; pattern values seed+0..seed+3.
- Waitrequest stalls: random m_waitrequest at 50% with READ_LATENCY=2 model -> outputs held stable during stalls; 8-word verify returns err_count=0; exactly 8 compares occur.
- Zero length and ignored start: len=0 -> no chipselect, done 2 cycles after start. A second start issued while busy -> ignored; transfer count unchanged.
- Reset mid-verify: assert reset at word 5 of 20 -> m_chipselect=0 and busy=0 next cycle; no done pulse; err_count=0; a new start after reset runs normally.

Source files
------------

// File: rtl/jtag_debug_sys_mem_tester_if.sv
// Avalon-MM master/slave bundle between the memory tester and the on-chip memory s1 port.
interface jtag_debug_sys_mem_tester_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_waitrequest;
    logic                m_clken;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata, m_waitrequest
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata, m_waitrequest
    );
endinterface

// File: rtl/jtag_debug_sys_mem_tester.sv
// Debug memory tester: fills a word window with a seed/incrementing pattern or reads it
// back through a fixed-latency compare pipe, recording mismatch count and first failure.
module jtag_debug_sys_mem_tester #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      op,
    input  logic                      pat_incr,
    input  logic [ADDR_W-1:0]         base,
    input  logic [ADDR_W:0]           len,
    input  logic [DATA_W-1:0]         seed,
    jtag_debug_sys_mem_tester_if.master avm,
    output logic                      busy,
    output logic                      done,
    output logic [ERR_W-1:0]          err_count,
    output logic                      first_err_valid,
    output logic [ADDR_W-1:0]         first_err_addr,
    output logic [DATA_W-1:0]         first_err_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] pattern_at(input logic [DATA_W-1:0] s,
                                                     input logic             inc,
                                                     input logic [ADDR_W:0]  i);
        return inc ? s + DATA_W'(i) : s;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic [1:0]        state;
    logic              op_q;
    logic              incr_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic [DATA_W-1:0] seed_q;

    logic              issue;
    logic              accept;
    logic              last_word;
    logic [ADDR_W:0]   idx_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_pat;
    logic              rd_pending;
    logic              rd_mismatch;

    logic              rd_vld_p  [READ_LATENCY];
    logic [ADDR_W-1:0] rd_addr_p [READ_LATENCY];
    logic [DATA_W-1:0] rd_exp_p  [READ_LATENCY];

    // p0: issue stage, bus outputs are decoded from state so they hold during stalls
    assign issue     = (state == S_ISSUE);
    assign accept    = issue && !avm.m_waitrequest;
    assign idx_nxt   = idx_q + IDX_ONE;
    assign last_word = (idx_nxt == len_q);
    assign cur_addr  = base_q + idx_q[ADDR_W-1:0];
    assign cur_pat   = pattern_at(seed_q, incr_q, idx_q);

    assign avm.m_chipselect = issue;
    assign avm.m_write      = issue && !op_q;
    assign avm.m_address    = issue ? cur_addr : '0;
    assign avm.m_writedata  = (issue && !op_q) ? cur_pat : '0;
    assign avm.m_byteenable = issue ? '1 : '0;
    assign avm.m_clken      = (state != S_IDLE);

    assign busy = issue || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= (len == '0) ? S_DONE : S_ISSUE;
                S_ISSUE: if (accept && last_word) state <= op_q ? S_DRAIN : S_DONE;
                S_DRAIN: if (!rd_pending) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            op_q   <= op;
            incr_q <= pat_incr;
            base_q <= base;
            len_q  <= len;
            seed_q <= seed;
            idx_q  <= '0;
        end else if (accept) begin
            idx_q <= idx_nxt;
        end
    end

    // p1..pN: read-return tracking, one entry per accepted read
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) rd_vld_p[k] <= 1'b0;
        end else begin
            rd_vld_p[0] <= accept && op_q;
            for (int k = 1; k < READ_LATENCY; k++) rd_vld_p[k] <= rd_vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        rd_addr_p[0] <= cur_addr;
        rd_exp_p[0]  <= cur_pat;
        for (int k = 1; k < READ_LATENCY; k++) begin
            rd_addr_p[k] <= rd_addr_p[k-1];
            rd_exp_p[k]  <= rd_exp_p[k-1];
        end
    end

    // The entry in the last stage is compared this cycle, so only younger stages block DONE.
    always_comb begin
        rd_pending = 1'b0;
        for (int k = 0; k < READ_LATENCY - 1; k++) rd_pending = rd_pending | rd_vld_p[k];
    end

    assign rd_mismatch = rd_vld_p[READ_LATENCY-1] &&
                         (avm.m_readdata != rd_exp_p[READ_LATENCY-1]);

    // compare stage: error bookkeeping
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && start)) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
        end else if (rd_mismatch) begin
            err_count <= sat_inc(err_count);
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= rd_addr_p[READ_LATENCY-1];
                first_err_data  <= avm.m_readdata;
            end
        end
    end

endmodule

// File: tb/tb_jtag_debug_sys_mem_tester.sv
// Directed bench for the memory tester against a fixed-latency behavioural on-chip memory.
module tb_jtag_debug_sys_mem_tester;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic          pat_incr;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic [EW-1:0] err_count;
    logic          first_err_valid;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    jtag_debug_sys_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    jtag_debug_sys_mem_tester #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .ERR_W(EW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .pat_incr        (pat_incr),
        .base            (base),
        .len             (len),
        .seed            (seed),
        .avm             (bus),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data)
    );

    always #5 clk = ~clk;

    // behavioural memory: writes on acceptance, readdata RL cycles after the address
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rpipe [RL];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (bus.m_chipselect && !bus.m_waitrequest && bus.m_write)
            mem[bus.m_address] <= bus.m_writedata;
        rpipe[0] <= mem[bus.m_address];
        for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
    end
    assign bus.m_readdata = rpipe[RL-1];

    int total = 0;
    int bad   = 0;

    int n_acc, n_wr, done_cnt, done_cycle, first_acc, last_acc;
    int busy_bad, stab_bad, be_bad, cs_seen;
    int timed_out;
    logic [AW-1:0] acc_addr [32];
    logic [DW-1:0] acc_data [32];

    task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    // Issues one command and records bus activity cycle by cycle (cycle 1 = first after start).
    task automatic run_op(input logic o, input logic inc, input logic [AW-1:0] b,
                          input logic [AW:0] l, input logic [DW-1:0] s, input bit stall,
                          input int restart_at, input int budget);
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        logic          prev_wr;
        n_acc = 0; n_wr = 0; done_cnt = 0; done_cycle = -1; first_acc = -1; last_acc = -1;
        busy_bad = 0; stab_bad = 0; be_bad = 0; cs_seen = 0; timed_out = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0; prev_wr = 1'b0;
        @(negedge clk);
        op = o; pat_incr = inc; base = b; len = l; seed = s; start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            bus.m_waitrequest = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (prev_stall && (!bus.m_chipselect || bus.m_address !== prev_addr ||
                               bus.m_writedata !== prev_data || bus.m_write !== prev_wr))
                stab_bad++;
            if (bus.m_chipselect) begin
                cs_seen++;
                if (bus.m_byteenable !== 4'hF) be_bad++;
                if (!bus.m_waitrequest) begin
                    if (n_acc < 32) begin
                        acc_addr[n_acc] = bus.m_address;
                        acc_data[n_acc] = bus.m_writedata;
                    end
                    if (bus.m_write) n_wr++;
                    if (first_acc < 0) first_acc = c;
                    last_acc = c;
                    n_acc++;
                end
            end
            prev_stall = bus.m_chipselect && bus.m_waitrequest;
            prev_addr  = bus.m_address;
            prev_data  = bus.m_writedata;
            prev_wr    = bus.m_write;
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (busy !== (done_cycle < 0)) busy_bad++;
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
        end
        if (done_cycle < 0) timed_out = 1;
        start = 1'b0;
        bus.m_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; pat_incr = 1'b0;
        base = '0; len = '0; seed = '0; bus.m_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.m_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs: got %b want 0", bus.m_chipselect); end
        total++; if (bus.m_clken !== 1'b0) begin bad++; $display("FAIL rst_clken: got %b want 0", bus.m_clken); end
        total++; if (bus.m_byteenable !== 4'h0) begin bad++; $display("FAIL rst_be: got %h want 0", bus.m_byteenable); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", err_count); end
        total++; if (first_err_valid !== 1'b0) begin bad++; $display("FAIL rst_fev: got %b want 0", first_err_valid); end
        reset = 1'b0;
    endtask

    task automatic test_fill_verify_full();
        run_op(1'b0, 1'b1, 10'h000, 11'd1024, 32'h1000_0000, 1'b0, 0, 1200);
        total++; if (timed_out !== 0) begin bad++; $display("FAIL full_fill_timeout: got %0d want 0", timed_out); end
        total++; if (n_acc !== 1024) begin bad++; $display("FAIL full_fill_nacc: got %0d want 1024", n_acc); end
        total++; if (n_wr !== 1024) begin bad++; $display("FAIL full_fill_nwr: got %0d want 1024", n_wr); end
        total++; if (last_acc - first_acc !== 1023) begin bad++; $display("FAIL full_fill_span: got %0d want 1023", last_acc - first_acc); end
        total++; if (done_cycle - last_acc !== 1) begin bad++; $display("FAIL full_fill_lat: got %0d want 1", done_cycle - last_acc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_fill_donecnt: got %0d want 1", done_cnt); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL full_fill_busy: got %0d want 0", busy_bad); end
        total++; if (acc_data[5] !== 32'h1000_0005) begin bad++; $display("FAIL full_fill_wd5: got %h want 10000005", acc_data[5]); end
        total++; if (mem[5] !== 32'h1000_0005) begin bad++; $display("FAIL full_fill_mem5: got %h want 10000005", mem[5]); end
        total++; if (mem[1023] !== 32'h1000_03FF) begin bad++; $display("FAIL full_fill_mem1023: got %h want 100003ff", mem[1023]); end
        run_op(1'b1, 1'b1, 10'h000, 11'd1024, 32'h1000_0000, 1'b0, 0, 1200);
        total++; if (n_acc !== 1024) begin bad++; $display("FAIL full_vfy_nacc: got %0d want 1024", n_acc); end
        total++; if (n_wr !== 0) begin bad++; $display("FAIL full_vfy_nwr: got %0d want 0", n_wr); end
        total++; if (done_cycle - last_acc !== RL + 1) begin bad++; $display("FAIL full_vfy_lat: got %0d want %0d", done_cycle - last_acc, RL + 1); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL full_vfy_err: got %0d want 0", err_count); end
        total++; if (first_err_valid !== 1'b0) begin bad++; $display("FAIL full_vfy_fev: got %b want 0", first_err_valid); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL full_vfy_busy: got %0d want 0", busy_bad); end
    endtask

    task automatic test_mismatch();
        run_op(1'b0, 1'b0, 10'h000, 11'd16, 32'hA5A5_A5A5, 1'b0, 0, 100);
        backdoor(10'd3, 32'h0);
        backdoor(10'd9, 32'h0);
        run_op(1'b1, 1'b0, 10'h000, 11'd16, 32'hA5A5_A5A5, 1'b0, 0, 100);
        total++; if (err_count !== 16'd2) begin bad++; $display("FAIL mm_err: got %0d want 2", err_count); end
        total++; if (first_err_valid !== 1'b1) begin bad++; $display("FAIL mm_fev: got %b want 1", first_err_valid); end
        total++; if (first_err_addr !== 10'd3) begin bad++; $display("FAIL mm_addr: got %h want 3", first_err_addr); end
        total++; if (first_err_data !== 32'h0) begin bad++; $display("FAIL mm_data: got %h want 0", first_err_data); end
        total++; if (done_cycle - last_acc !== RL + 1) begin bad++; $display("FAIL mm_lat: got %0d want %0d", done_cycle - last_acc, RL + 1); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] wa [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [DW-1:0] wd [4] = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
        run_op(1'b0, 1'b1, 10'h3FE, 11'd4, 32'hDEAD_0000, 1'b0, 0, 50);
        total++; if (n_acc !== 4) begin bad++; $display("FAIL wrap_nacc: got %0d want 4", n_acc); end
        for (int i = 0; i < 4; i++) begin
            total++; if (acc_addr[i] !== wa[i]) begin bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, acc_addr[i], wa[i]); end
            total++; if (acc_data[i] !== wd[i]) begin bad++; $display("FAIL wrap_data%0d: got %h want %h", i, acc_data[i], wd[i]); end
        end
        total++; if (mem[0] !== 32'hDEAD_0002) begin bad++; $display("FAIL wrap_mem0: got %h want dead0002", mem[0]); end
        run_op(1'b1, 1'b1, 10'h3FE, 11'd4, 32'hDEAD_0000, 1'b0, 0, 50);
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL wrap_vfy_err: got %0d want 0", err_count); end
    endtask

    task automatic test_stall();
        run_op(1'b0, 1'b1, 10'h100, 11'd8, 32'h0000_0055, 1'b1, 0, 200);
        total++; if (timed_out !== 0) begin bad++; $display("FAIL stall_fill_timeout: got %0d want 0", timed_out); end
        total++; if (n_acc !== 8) begin bad++; $display("FAIL stall_fill_nacc: got %0d want 8", n_acc); end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL stall_fill_stable: got %0d want 0", stab_bad); end
        total++; if (be_bad !== 0) begin bad++; $display("FAIL stall_fill_be: got %0d want 0", be_bad); end
        total++; if (mem[10'h107] !== 32'h0000_005C) begin bad++; $display("FAIL stall_fill_mem: got %h want 5c", mem[10'h107]); end
        run_op(1'b1, 1'b1, 10'h100, 11'd8, 32'h0000_0055, 1'b1, 0, 200);
        total++; if (n_acc !== 8) begin bad++; $display("FAIL stall_vfy_nacc: got %0d want 8", n_acc); end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL stall_vfy_stable: got %0d want 0", stab_bad); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL stall_vfy_err: got %0d want 0", err_count); end
        total++; if (done_cycle - last_acc !== RL + 1) begin bad++; $display("FAIL stall_vfy_lat: got %0d want %0d", done_cycle - last_acc, RL + 1); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL stall_vfy_busy: got %0d want 0", busy_bad); end
    endtask

    task automatic test_zero_len_and_ignored_start();
        run_op(1'b0, 1'b0, 10'h050, 11'd0, 32'h1234_5678, 1'b0, 0, 20);
        total++; if (cs_seen !== 0) begin bad++; $display("FAIL zero_cs: got %0d want 0", cs_seen); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_donecnt: got %0d want 1", done_cnt); end
        total++; if ((done_cycle >= 1 && done_cycle <= 2) !== 1'b1) begin bad++; $display("FAIL zero_donecyc: got %0d want 1..2", done_cycle); end
        run_op(1'b0, 1'b0, 10'h200, 11'd6, 32'h0000_0077, 1'b0, 2, 50);
        total++; if (n_acc !== 6) begin bad++; $display("FAIL ign_nacc: got %0d want 6", n_acc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL ign_donecnt: got %0d want 1", done_cnt); end
        total++; if (mem[10'h205] !== 32'h0000_0077) begin bad++; $display("FAIL ign_mem: got %h want 77", mem[10'h205]); end
    endtask

    task automatic test_reset_mid();
        int   acc = 0;
        int   fire_c = -1;
        int   dn = 0;
        int   cs_after = 0;
        logic cs_at = 1'b1;
        logic busy_at = 1'b1;
        @(negedge clk);
        op = 1'b1; pat_incr = 1'b1; base = 10'h000; len = 11'd20; seed = 32'hFFFF_0000; start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (fire_c >= 0) begin
                if (c == fire_c + 1) begin
                    cs_at = bus.m_chipselect;
                    busy_at = busy;
                    reset = 1'b0;
                end
                if (done) dn++;
                if (bus.m_chipselect) cs_after++;
            end else if (bus.m_chipselect) begin
                acc++;
                if (acc == 5) begin
                    reset = 1'b1;
                    fire_c = c;
                end
            end
        end
        reset = 1'b0;
        total++; if (fire_c < 0) begin bad++; $display("FAIL rmid_reached: got %0d accepts want 5", acc); end
        total++; if (cs_at !== 1'b0) begin bad++; $display("FAIL rmid_cs: got %b want 0", cs_at); end
        total++; if (busy_at !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy_at); end
        total++; if (dn !== 0) begin bad++; $display("FAIL rmid_done: got %0d want 0", dn); end
        total++; if (cs_after !== 0) begin bad++; $display("FAIL rmid_cs_after: got %0d want 0", cs_after); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rmid_err: got %0d want 0", err_count); end
        run_op(1'b0, 1'b0, 10'h300, 11'd8, 32'h0000_0001, 1'b0, 0, 50);
        total++; if (n_acc !== 8) begin bad++; $display("FAIL rmid_post_nacc: got %0d want 8", n_acc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL rmid_post_done: got %0d want 1", done_cnt); end
        total++; if (mem[10'h307] !== 32'h0000_0001) begin bad++; $display("FAIL rmid_post_mem: got %h want 1", mem[10'h307]); end
    endtask

    initial begin
        bus.m_waitrequest = 1'b0;
        test_reset();
        test_fill_verify_full();
        test_mismatch();
        test_wrap();
        test_stall();
        test_zero_len_and_ignored_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
